// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - shared types and constants for the 68000 bus target
package m68k_bus_pkg;

    // Target cycle states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IGNORE = 3'd1,
        S_STRB   = 3'd2,
        S_REQ    = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    // Byte-lane encodings presented on LOC_BE as {upper, lower}
    localparam logic [1:0] BE_NONE  = 2'b00;
    localparam logic [1:0] BE_LOWER = 2'b01;
    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_BOTH  = 2'b11;

    // Default decode window and timing
    localparam logic [23:0] DEF_ADDR_BASE   = 24'hE80000;
    localparam logic [23:0] DEF_ADDR_MASK   = 24'hFF0000;
    localparam int          DEF_TIMEOUT_CYC = 255;
    localparam int          DEF_SYNC_STAGES = 2;

    // Map the active-low data strobes onto a byte-enable pair
    function automatic logic [1:0] lane_enables(input logic uds_n, input logic lds_n);
        logic [1:0] be;
        case ({uds_n, lds_n})
            2'b00:   be = BE_BOTH;
            2'b01:   be = BE_UPPER;
            2'b10:   be = BE_LOWER;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/m68k_in_sync.sv
// rtl/m68k_in_sync.sv - multi-flop synchroniser bank for the async bus strobes
module m68k_in_sync
    import m68k_bus_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES,
    parameter int WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    // Shift chain: stage 0 takes the raw pins, each later stage the one before
    always_comb begin
        sync_d[0] = async_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Strobes are active low, so reset every stage to the inactive level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_target.sv
// rtl/m68k_bus_target.sv - 68000 bus target with local req/ack port; BERR timeout via M68K_TGT_BERR_TIMEOUT_EN
module m68k_bus_target
    import m68k_bus_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE   = DEF_ADDR_BASE,
    parameter logic [23:0] ADDR_MASK   = DEF_ADDR_MASK,
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int          SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic        PI_CLK,
    input  logic        RESET,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    input  logic [22:0] M68K_A,
    input  logic [15:0] M68K_D_IN,
    output logic [15:0] M68K_D_OUT,
    output logic        M68K_D_OE,
    output logic        M68K_DTACK_OE,
    output logic        M68K_BERR_OE,
    output logic        LOC_REQ,
    output logic        LOC_WE,
    output logic [22:0] LOC_ADDR,
    output logic [1:0]  LOC_BE,
    output logic [15:0] LOC_WDATA,
    input  logic [15:0] LOC_RDATA,
    input  logic        LOC_ACK
);

    // Word-address bits left after removing the window-select bits
    localparam logic [22:0] LOC_ADDR_KEEP = ~ADDR_MASK[23:1];

    logic [2:0] strb_s;
    logic       as_s;
    logic       uds_s;
    logic       lds_s;
    logic       hit;
    logic       aborted;
    logic       timeout;

    state_t      state_q,     state_d;
    logic        loc_req_q,   loc_req_d;
    logic        loc_we_q,    loc_we_d;
    logic [22:0] loc_addr_q,  loc_addr_d;
    logic [1:0]  loc_be_q,    loc_be_d;
    logic [15:0] loc_wdata_q, loc_wdata_d;
    logic [15:0] d_out_q,     d_out_d;
    logic        d_oe_q,      d_oe_d;
    logic        dtack_oe_q,  dtack_oe_d;
    logic        berr_oe_q,   berr_oe_d;
    logic        abort_q,     abort_d;

    m68k_in_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (3)
    ) u_in_sync (
        .clk      (PI_CLK),
        .rst      (RESET),
        .async_in ({M68K_AS_n, M68K_UDS_n, M68K_LDS_n}),
        .sync_out (strb_s)
    );

    assign as_s  = strb_s[2];
    assign uds_s = strb_s[1];
    assign lds_s = strb_s[0];

    // Address is stable once AS is seen asserted, so it is decoded raw
    assign hit = (({M68K_A, 1'b0} & ADDR_MASK) == ADDR_BASE);

    // A master that has let go of AS during the request no longer wants DTACK
    assign aborted = abort_q | as_s;

`ifdef M68K_TGT_BERR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == S_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Count cycles spent waiting for the local side; restart on each new request
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_STRB) begin
            cnt_d = '0;
        end else if (state_q == S_REQ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    // Bus-cycle sequencing: decode, capture, hand off, terminate, release
    always_comb begin
        state_d     = state_q;
        loc_req_d   = loc_req_q;
        loc_we_d    = loc_we_q;
        loc_addr_d  = loc_addr_q;
        loc_be_d    = loc_be_q;
        loc_wdata_d = loc_wdata_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        dtack_oe_d  = dtack_oe_q;
        berr_oe_d   = berr_oe_q;
        abort_d     = abort_q;

        case (state_q)
            S_IDLE: begin
                if (!as_s) begin
                    state_d = hit ? S_STRB : S_IGNORE;
                end
            end

            S_IGNORE: begin
                if (as_s) begin
                    state_d = S_IDLE;
                end
            end

            S_STRB: begin
                if (as_s) begin
                    state_d = S_IDLE;
                end else if (!uds_s || !lds_s) begin
                    loc_addr_d = M68K_A & LOC_ADDR_KEEP;
                    loc_we_d   = ~M68K_RW;
                    loc_be_d   = lane_enables(uds_s, lds_s);
                    if (!M68K_RW) begin
                        loc_wdata_d = M68K_D_IN;
                    end
                    loc_req_d = 1'b1;
                    abort_d   = 1'b0;
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                abort_d = aborted;
                if (LOC_ACK || timeout) begin
                    loc_req_d = 1'b0;
                    if (aborted) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACK;
                        if (LOC_ACK) begin
                            dtack_oe_d = 1'b1;
                            if (!loc_we_q) begin
                                d_oe_d  = 1'b1;
                                d_out_d = LOC_RDATA;
                            end
                        end else begin
                            berr_oe_d = 1'b1;
                        end
                    end
                end
            end

            S_ACK: begin
                if (as_s) begin
                    dtack_oe_d = 1'b0;
                    berr_oe_d  = 1'b0;
                    d_oe_d     = 1'b0;
                    d_out_d    = 16'h0000;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            loc_req_q   <= 1'b0;
            loc_we_q    <= 1'b0;
            loc_addr_q  <= '0;
            loc_be_q    <= BE_NONE;
            loc_wdata_q <= '0;
            d_out_q     <= '0;
            d_oe_q      <= 1'b0;
            dtack_oe_q  <= 1'b0;
            berr_oe_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            loc_req_q   <= loc_req_d;
            loc_we_q    <= loc_we_d;
            loc_addr_q  <= loc_addr_d;
            loc_be_q    <= loc_be_d;
            loc_wdata_q <= loc_wdata_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            dtack_oe_q  <= dtack_oe_d;
            berr_oe_q   <= berr_oe_d;
            abort_q     <= abort_d;
        end
    end

    assign M68K_D_OUT    = d_out_q;
    assign M68K_D_OE     = d_oe_q;
    assign M68K_DTACK_OE = dtack_oe_q;
    assign M68K_BERR_OE  = berr_oe_q;
    assign LOC_REQ       = loc_req_q;
    assign LOC_WE        = loc_we_q;
    assign LOC_ADDR      = loc_addr_q;
    assign LOC_BE        = loc_be_q;
    assign LOC_WDATA     = loc_wdata_q;

endmodule
